// File: rtl/util_ext_sync_ctrl.sv
// External-sync trigger sequencer: arms on a register request, waits for a
// synchronized rising edge of sync_in, applies a delay and emits trigger shots.
module util_ext_sync_ctrl #(
  parameter int ENABLED       = 1,
  parameter int DELAY_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH = 32,
  parameter int SHOTS_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_arm,
  input  logic                     cfg_disarm,
  input  logic [DELAY_WIDTH-1:0]   cfg_delay,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic [SHOTS_WIDTH-1:0]   cfg_shots,
  input  logic                     sync_in,
  output logic                     sync_armed,
  output logic                     sync_out,
  output logic                     sync_done,
  output logic                     timeout_err,
  output logic [SHOTS_WIDTH-1:0]   shot_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2
  } state_e;

  localparam logic                     EN       = (ENABLED != 0);
  localparam logic [DELAY_WIDTH-1:0]   DLY_ZERO = {DELAY_WIDTH{1'b0}};
  localparam logic [DELAY_WIDTH-1:0]   DLY_ONE  = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ZERO = {TIMEOUT_WIDTH{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHOTS_WIDTH-1:0]   SHT_ZERO = {SHOTS_WIDTH{1'b0}};

  state_e                     state_q, state_d;
  logic                       m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic                       arm_d1_q, arm_d1_d, disarm_d1_q, disarm_d1_d;
  logic [DELAY_WIDTH-1:0]     delay_q, delay_d, dly_cnt_q, dly_cnt_d;
  logic [TIMEOUT_WIDTH-1:0]   timeout_q, timeout_d, tmo_cnt_q, tmo_cnt_d;
  logic [SHOTS_WIDTH-1:0]     shots_q, shots_d, shot_count_q, shot_count_d;
  logic                       sync_armed_q, sync_armed_d;
  logic                       sync_out_q, sync_out_d;
  logic                       sync_done_q, sync_done_d;
  logic                       timeout_err_q, timeout_err_d;

  logic                       sync_edge_s, arm_edge_s, disarm_edge_s, fire_s;
  logic [SHOTS_WIDTH:0]       shot_inc_s;

  // Edge detection; a disabled build never sees an arm request and so never leaves IDLE.
  assign sync_edge_s   = m2_q & ~m3_q;
  assign arm_edge_s    = EN & cfg_arm & ~arm_d1_q;
  assign disarm_edge_s = cfg_disarm & ~disarm_d1_q;
  assign shot_inc_s    = {1'b0, shot_count_q} + {{SHOTS_WIDTH{1'b0}}, 1'b1};

  // Next-state, counter and output computation.
  always_comb begin
    state_d       = state_q;
    m1_d          = sync_in;
    m2_d          = m1_q;
    m3_d          = m2_q;
    arm_d1_d      = cfg_arm;
    disarm_d1_d   = cfg_disarm;
    delay_d       = delay_q;
    timeout_d     = timeout_q;
    shots_d       = shots_q;
    dly_cnt_d     = dly_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    shot_count_d  = shot_count_q;
    timeout_err_d = timeout_err_q;
    sync_out_d    = 1'b0;
    sync_done_d   = 1'b0;
    sync_armed_d  = (state_q != ST_IDLE);
    fire_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (disarm_edge_s) begin
          state_d = ST_IDLE;
        end else if (arm_edge_s) begin
          delay_d       = cfg_delay;
          timeout_d     = cfg_timeout;
          shots_d       = cfg_shots;
          tmo_cnt_d     = cfg_timeout;
          shot_count_d  = SHT_ZERO;
          timeout_err_d = 1'b0;
          state_d       = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (disarm_edge_s) begin
          state_d = ST_IDLE;
        end else if ((timeout_q != TMO_ZERO) && (tmo_cnt_q == TMO_ONE)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (sync_edge_s) begin
          if (delay_q == DLY_ZERO) begin
            fire_s = 1'b1;
          end else begin
            dly_cnt_d = delay_q;
            state_d   = ST_DELAY;
          end
        end else if (timeout_q != TMO_ZERO) begin
          tmo_cnt_d = tmo_cnt_q - TMO_ONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end
      // Timeout is frozen here; it is reloaded after the shot anyway.
      ST_DELAY: begin
        if (disarm_edge_s) begin
          state_d = ST_IDLE;
        end else if (dly_cnt_q == DLY_ONE) begin
          fire_s = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fire_s) begin
      sync_out_d   = 1'b1;
      shot_count_d = (&shot_count_q) ? shot_count_q : shot_inc_s[SHOTS_WIDTH-1:0];
      if ((shots_q != SHT_ZERO) && (shot_inc_s == {1'b0, shots_q})) begin
        sync_done_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        tmo_cnt_d = timeout_q;
        state_d   = ST_ARMED;
      end
    end else begin
      sync_out_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      m1_q          <= 1'b0;
      m2_q          <= 1'b0;
      m3_q          <= 1'b0;
      arm_d1_q      <= 1'b0;
      disarm_d1_q   <= 1'b0;
      delay_q       <= DLY_ZERO;
      timeout_q     <= TMO_ZERO;
      shots_q       <= SHT_ZERO;
      dly_cnt_q     <= DLY_ZERO;
      tmo_cnt_q     <= TMO_ZERO;
      shot_count_q  <= SHT_ZERO;
      timeout_err_q <= 1'b0;
      sync_out_q    <= 1'b0;
      sync_done_q   <= 1'b0;
      sync_armed_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      m1_q          <= m1_d;
      m2_q          <= m2_d;
      m3_q          <= m3_d;
      arm_d1_q      <= arm_d1_d;
      disarm_d1_q   <= disarm_d1_d;
      delay_q       <= delay_d;
      timeout_q     <= timeout_d;
      shots_q       <= shots_d;
      dly_cnt_q     <= dly_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      shot_count_q  <= shot_count_d;
      timeout_err_q <= timeout_err_d;
      sync_out_q    <= sync_out_d;
      sync_done_q   <= sync_done_d;
      sync_armed_q  <= sync_armed_d;
    end
  end

  assign sync_armed  = sync_armed_q;
  assign sync_out    = sync_out_q;
  assign sync_done   = sync_done_q;
  assign timeout_err = timeout_err_q;
  assign shot_count  = shot_count_q;

endmodule
